// File: rtl/animate_sprite_h.sv
// animate_sprite_h
//   Horizontal sprite animator for the 160x120 VGA adapter path. Each go
//   pulse erases the sprite at its current x, moves it one step left or
//   right (clamped to the screen), redraws it and pulses done. A built-in
//   raster scanner drives the VGA plot interface directly.
//
//   Ports:
//     clock        system clock, all logic on posedge
//     reset        synchronous active-high reset
//     go           start one frame (sampled only while idle)
//     left, right  active-low move requests, sampled in the shift state
//     vga_x/vga_y  registered pixel coordinates
//     colour       registered pixel colour
//     plot         registered pixel write enable
//     out_x        current sprite left-edge x
//     busy         high whenever a frame is in progress
//     done         one-cycle pulse at frame end
//
//   Build option: ANIM_ACCEL_EN enables step acceleration while the same
//   direction is held across consecutive frames (capped at MAX_STEP).
module animate_sprite_h #(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COLOUR_W  = 3,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SPRITE_W  = 20,
    parameter int unsigned SPRITE_H  = 20,
    parameter int unsigned Y_POS     = 100,
    parameter int unsigned INIT_X    = 70,
    parameter int unsigned STEP      = 7,
    parameter int unsigned MAX_STEP  = 10,
    parameter logic [COLOUR_W-1:0] FG_COLOUR = '1,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                left,
    input  logic                right,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [X_W-1:0]      out_x,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned CY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [2:0] {IDLE, ERASE, SHIFT, DRAW, DONE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

    state_t          state;
    logic [X_W-1:0]  pos_x;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;

    dir_t            dir;
    logic [X_W:0]    step_w;
    logic [X_W:0]    next_pos;
    logic [X_W:0]    sum_w;
    logic [X_W:0]    lim_w;

`ifdef ANIM_ACCEL_EN
    logic [X_W:0]    cur_step;
    logic [X_W:0]    next_step;
    dir_t            prev_dir;
`else
    logic [X_W:0]    unused_max_step;
    assign unused_max_step = (X_W+1)'(MAX_STEP);
`endif

    assign out_x = pos_x;

    // Move computation is one bit wider than the position so neither the
    // subtraction nor the addition can wrap before clamping.
    always_comb begin
        dir = DIR_NONE;
        if (!left && right)
            dir = DIR_L;
        else if (!right && left)
            dir = DIR_R;

`ifdef ANIM_ACCEL_EN
        // A fresh direction restarts at STEP for this move; each moving frame
        // then bumps the stored step for the next frame in the same direction.
        step_w = (dir != DIR_NONE && dir == prev_dir) ? cur_step : (X_W+1)'(STEP);
        next_step = ((step_w + 1'b1) > (X_W+1)'(MAX_STEP)) ? (X_W+1)'(MAX_STEP)
                                                          : step_w + 1'b1;
`else
        step_w = (X_W+1)'(STEP);
`endif

        lim_w    = (X_W+1)'(SCREEN_W - SPRITE_W);
        sum_w    = {1'b0, pos_x} + step_w;
        next_pos = {1'b0, pos_x};
        if (dir == DIR_L)
            next_pos = ({1'b0, pos_x} < step_w) ? '0 : {1'b0, pos_x} - step_w;
        else if (dir == DIR_R)
            next_pos = (sum_w > lim_w) ? lim_w : sum_w;
    end

    // Pixel outputs are registered from the scan counters, so each plotted
    // pixel appears one cycle after the counter value that produced it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pos_x    <= X_W'(INIT_X);
            cx       <= '0;
            cy       <= '0;
            vga_x    <= '0;
            vga_y    <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef ANIM_ACCEL_EN
            cur_step <= (X_W+1)'(STEP);
            prev_dir <= DIR_NONE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (go) begin
                        state <= ERASE;
                        busy  <= 1'b1;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                ERASE, DRAW: begin
                    plot   <= 1'b1;
                    vga_x  <= pos_x + X_W'(cx);
                    vga_y  <= Y_W'(Y_POS) + Y_W'(cy);
                    colour <= (state == ERASE) ? BG_COLOUR : FG_COLOUR;
                    if (cx == CX_W'(SPRITE_W - 1)) begin
                        cx <= '0;
                        if (cy == CY_W'(SPRITE_H - 1)) begin
                            cy    <= '0;
                            state <= (state == ERASE) ? SHIFT : DONE;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                SHIFT: begin
                    plot  <= 1'b0;
                    pos_x <= next_pos[X_W-1:0];
`ifdef ANIM_ACCEL_EN
                    cur_step <= (dir == DIR_NONE) ? (X_W+1)'(STEP) : next_step;
                    prev_dir <= dir;
`endif
                    state <= DRAW;
                end
                DONE: begin
                    plot  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
